ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver with a first-word-fall-through (FWFT) scancode FIFO. Serves both keyboard and mouse ports. It generalises the single-register receiver in four ways: the deglitch length, the timeout width and the FIFO depth are configurable; frame errors are reported; keyboard E0/F0 prefixes are folded into each FIFO entry; and received bytes are buffered, so the consumer (CPC keyboard matrix or mouse decoder) can stall without losing codes.

---
 rtl/ps2_rx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a deglitching edge detector, frame checking,
// keyboard E0/F0 prefix folding and a first-word-fall-through scancode FIFO.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data=0 on a falling PS/2 clock edge)
// S_DATA   | shifting in 8 data bits LSB first; sentinel marks the 8th bit
// S_PARITY | checking odd parity over data + parity bit
// S_STOP   | checking stop bit, delivering the byte when it is 1
module ps2_rx_fifo #(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT_W  = 16,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_rcv,
  input  logic               kb_or_mouse,
  input  logic               ps2clk_ext,
  input  logic               ps2data_ext,
  input  logic               rd_en,
  input  logic               clear_ovf,
  output logic               rd_valid,
  output logic [9:0]         rd_data,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               frame_err
);

  localparam int QTR   = FILTER_LEN / 4;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic                  clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  state_t                state_q, state_d;
  logic [7:0]            key_q, key_d;
  logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;
  logic                  pend_ext_q, pend_ext_d, pend_rel_q, pend_rel_d;
  logic                  ferr_q, ferr_d;
  logic                  ovf_q;
  logic [FIFO_AW:0]      wr_ptr_q, rd_ptr_q;
  logic [9:0]            mem_q [DEPTH];

  logic                  ps2_edge, adv, timeout, deliver;
  logic                  push_req, push, pop, drop, empty, full;
  logic [9:0]            push_data;
  logic [FIFO_AW:0]      fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
      hist_q     <= '0;
    end else begin
      clk_meta_q <= ps2clk_ext;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2data_ext;
      dat_sync_q <= dat_meta_q;
      hist_q     <= {hist_q[FILTER_LEN-2:0], clk_sync_q};
    end
  end

  // Oldest quarter high, newest three quarters low: matches exactly once per clean fall.
  assign ps2_edge = (&hist_q[FILTER_LEN-1 -: QTR]) && !(|hist_q[FILTER_LEN-QTR-1:0]);
  assign adv      = ps2_edge && enable_rcv;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    ferr_d   = 1'b0;
    deliver  = 1'b0;
    timeout  = 1'b0;
    to_cnt_d = to_cnt_q + 1'b1;
    if (adv) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_sync_q) begin
            state_d = S_DATA;
            key_d   = 8'h80;
          end
        end
        S_DATA: begin
          key_d = {dat_sync_q, key_q[7:1]};
          if (key_q[0]) state_d = S_PARITY;
        end
        S_PARITY: begin
          if (dat_sync_q ^ (^key_q)) begin
            state_d = S_STOP;
          end else begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
          end
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_sync_q) deliver = 1'b1;
          else            ferr_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (&to_cnt_q) begin
      timeout = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_comb begin
    pend_ext_d = pend_ext_q;
    pend_rel_d = pend_rel_q;
    push_req   = 1'b0;
    push_data  = '0;
    if (timeout) begin
      pend_ext_d = 1'b0;
      pend_rel_d = 1'b0;
    end else if (deliver) begin
      if (kb_or_mouse) begin
        push_req  = 1'b1;
        push_data = {2'b00, key_q};
      end else if (key_q == 8'hE0) begin
        pend_ext_d = 1'b1;
      end else if (key_q == 8'hF0) begin
        pend_rel_d = 1'b1;
      end else begin
        push_req   = 1'b1;
        push_data  = {pend_ext_q, pend_rel_q, key_q};
        pend_ext_d = 1'b0;
        pend_rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      to_cnt_q   <= '0;
      pend_ext_q <= 1'b0;
      pend_rel_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      to_cnt_q   <= to_cnt_d;
      pend_ext_q <= pend_ext_d;
      pend_rel_q <= pend_rel_d;
      ferr_q     <= ferr_d;
    end
  end

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign empty = (fill == '0);
  assign full  = (fill == DEPTH_C);
  assign pop   = rd_en && !empty;
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)           ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: the read port is gated by the empty flag.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
  end

  assign rd_valid  = !empty;
  assign rd_data   = empty ? 10'd0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign count     = fill;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames at 80-clk half periods,
// checked against hand-computed FIFO entries, flags and latencies.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       rst, enable_rcv, kb_or_mouse, ps2clk_ext, ps2data_ext, rd_en, clear_ovf;
  logic       rd_valid, overflow, frame_err;
  logic [9:0] rd_data;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_rises = 0;
  int fe_long  = 0;
  logic fe_prev = 1'b0;

  ps2_rx_fifo #(.FILTER_LEN(16), .TIMEOUT_W(12), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .enable_rcv(enable_rcv), .kb_or_mouse(kb_or_mouse),
    .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext), .rd_en(rd_en),
    .clear_ovf(clear_ovf), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err && !fe_prev) fe_rises++;
    if (frame_err && fe_prev)  fe_long++;
    fe_prev = frame_err;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: plain frame; 1: pop on the push cycle of the stop bit; 2: check push latency
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
    logic [10:0] bits;
    bits = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2data_ext = bits[i];
      repeat (80) @(negedge clk);
      ps2clk_ext = 1'b0;
      if (i == 10 && mode != 0) begin
        repeat (14) @(negedge clk);
        if (mode == 1) rd_en = 1'b1;
        else           check_eq("lat_before_push", rd_valid, 1'b0);
        @(negedge clk);
        if (mode == 1) rd_en = 1'b0;
        else           check_eq("lat_after_push", rd_valid, 1'b1);
        repeat (65) @(negedge clk);
      end else begin
        repeat (80) @(negedge clk);
      end
      ps2clk_ext = 1'b1;
    end
    ps2data_ext = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    check_eq(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int f0, l0;
    logic [10:0] pbits;
    rst = 1'b1; enable_rcv = 1'b1; kb_or_mouse = 1'b0;
    ps2clk_ext = 1'b1; ps2data_ext = 1'b1; rd_en = 1'b0; clear_ovf = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_count", count, 4'd0);
    check_eq("rst_rd_data", rd_data, 10'd0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // single keyboard byte, exact FWFT latency
    f0 = fe_rises;
    send_frame(8'h1C, 1'b0, 2);
    check_eq("kb1c_valid", rd_valid, 1'b1);
    check_eq("kb1c_data", rd_data, 10'h01C);
    check_eq("kb1c_count", count, 4'd1);
    check_eq("kb1c_no_ferr", fe_rises - f0, 0);
    pop_chk("kb1c_pop", 10'h01C);

    // prefix folding
    send_frame(8'hE0, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h75, 1'b0, 0);
    check_eq("fold_count", count, 4'd1);
    pop_chk("fold_data", 10'h375);
    check_eq("fold_empty_valid", rd_valid, 1'b0);
    check_eq("fold_empty_count", count, 4'd0);

    // mouse: raw bytes
    kb_or_mouse = 1'b1;
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h08, 1'b0, 0);
    check_eq("mouse_count", count, 4'd2);
    pop_chk("mouse_0", 10'h0F0);
    pop_chk("mouse_1", 10'h008);
    kb_or_mouse = 1'b0;

    // parity error then recovery
    f0 = fe_rises; l0 = fe_long;
    send_frame(8'h1C, 1'b1, 0);
    check_eq("par_ferr_pulses", fe_rises - f0, 1);
    check_eq("par_ferr_width", fe_long - l0, 0);
    check_eq("par_count", count, 4'd0);
    send_frame(8'h32, 1'b0, 0);
    check_eq("par_next_count", count, 4'd1);
    pop_chk("par_next_data", 10'h032);

    // overflow, clear, and push+pop while full
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0);
    check_eq("ovf_count", count, 4'd8);
    check_eq("ovf_flag", overflow, 1'b1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check_eq("ovf_cleared", overflow, 1'b0);
    check_eq("ovf_head", rd_data, 10'h001);
    send_frame(8'h0A, 1'b0, 1);
    check_eq("full_pp_count", count, 4'd8);
    check_eq("full_pp_ovf", overflow, 1'b0);
    for (int i = 2; i <= 8; i++) pop_chk("drain", 10'(i));
    pop_chk("drain_last", 10'h00A);
    check_eq("drain_count", count, 4'd0);

    // timeout clears a pending prefix
    send_frame(8'hE0, 1'b0, 0);
    repeat (4096 + 200) @(negedge clk);
    send_frame(8'h6B, 1'b0, 0);
    check_eq("tmo_count", count, 4'd1);
    pop_chk("tmo_data", 10'h06B);

    // reset in the middle of a frame with a non-empty FIFO
    send_frame(8'h11, 1'b0, 0);
    pbits = {1'b1, ~(^8'h22), 8'h22, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ps2data_ext = pbits[i];
      repeat (80) @(negedge clk);
      ps2clk_ext = 1'b0;
      repeat (80) @(negedge clk);
      ps2clk_ext = 1'b1;
    end
    ps2data_ext = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_rd_valid", rd_valid, 1'b0);
    check_eq("mrst_count", count, 4'd0);
    check_eq("mrst_rd_data", rd_data, 10'd0);
    check_eq("mrst_overflow", overflow, 1'b0);
    repeat (40) @(negedge clk);
    send_frame(8'h4D, 1'b0, 0);
    check_eq("mrst_next_count", count, 4'd1);
    pop_chk("mrst_next_data", 10'h04D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
